// File: rtl/vram_pkg.sv
// Shared VRAM geometry and command/state types for the character
// display path (scroll controller, vram, hdmi).
package vram_pkg;

    localparam int VRAM_ROW_W = 5;
    localparam int VRAM_COL_W = 7;
    localparam int VRAM_ROWS  = 32;

    typedef enum logic {
        CMD_SCROLL = 1'b0,
        CMD_CLEAR  = 1'b1
    } vram_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCROLL,
        ST_CLEAR,
        ST_DONE
    } scroll_state_t;

endpackage

// File: rtl/vram_scroll_controller.sv
// Owns top_row: passes character writes to VRAM with row translation and
// takes over the write port to blank a line (scroll) or all rows (clear).
module vram_scroll_controller
    import vram_pkg::*;
#(
    parameter int          VISIBLE_ROWS = 24,
    parameter int          COLS         = 80,
    parameter logic [7:0]  BLANK_BYTE   = 8'h20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  char_valid,
    output logic                  char_ready,
    input  logic [VRAM_ROW_W-1:0] char_row,
    input  logic [VRAM_COL_W-1:0] char_col,
    input  logic [7:0]            char_byte,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_op,
    output logic                  write_valid,
    input  logic                  write_ready,
    output logic [VRAM_ROW_W-1:0] write_row,
    output logic [VRAM_COL_W-1:0] write_col,
    output logic [7:0]            write_byte,
    output logic [VRAM_ROW_W-1:0] top_row,
    output logic                  busy
);

    localparam logic [VRAM_ROW_W-1:0] ROW_LAST =
        VRAM_ROW_W'(VRAM_ROWS - 1);
    localparam logic [VRAM_ROW_W-1:0] VIS_OFS =
        VRAM_ROW_W'(VISIBLE_ROWS % VRAM_ROWS);
    localparam logic [VRAM_COL_W-1:0] COL_LAST =
        VRAM_COL_W'(COLS - 1);

    scroll_state_t         state;
    vram_cmd_t             op;
    logic [VRAM_ROW_W-1:0] row_cnt;
    logic [VRAM_COL_W-1:0] col_cnt;

    logic idle_mode;
    logic blanking;
    logic xfer;

    // Reset forces pass-through behaviour even if a command was running.
    assign idle_mode = reset || (state == ST_IDLE);
    assign blanking  = !reset &&
                       (state == ST_SCROLL || state == ST_CLEAR);
    assign xfer      = write_valid && write_ready;

    always_comb begin
        char_ready  = 1'b0;
        write_valid = 1'b0;
        write_row   = char_row + top_row;
        write_col   = char_col;
        write_byte  = char_byte;
        if (idle_mode) begin
            write_valid = char_valid && !cmd_valid;
            char_ready  = write_ready && !cmd_valid;
        end else if (blanking) begin
            write_valid = 1'b1;
            write_row   = row_cnt;
            write_col   = col_cnt;
            write_byte  = BLANK_BYTE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            op        <= CMD_SCROLL;
            top_row   <= '0;
            row_cnt   <= '0;
            col_cnt   <= '0;
            busy      <= 1'b0;
            cmd_ready <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op      <= vram_cmd_t'(cmd_op);
                        col_cnt <= '0;
                        busy    <= 1'b1;
                        if (vram_cmd_t'(cmd_op) == CMD_CLEAR) begin
                            state   <= ST_CLEAR;
                            row_cnt <= '0;
                        end else begin
                            state   <= ST_SCROLL;
                            row_cnt <= top_row + VIS_OFS;
                        end
                    end
                end
                ST_SCROLL: begin
                    if (xfer) begin
                        col_cnt <= col_cnt + 1'b1;
                        if (col_cnt == COL_LAST) begin
                            state     <= ST_DONE;
                            cmd_ready <= 1'b1;
                        end
                    end
                end
                ST_CLEAR: begin
                    if (xfer) begin
                        if (col_cnt == COL_LAST) begin
                            col_cnt <= '0;
                            row_cnt <= row_cnt + 1'b1;
                            if (row_cnt == ROW_LAST) begin
                                state     <= ST_DONE;
                                cmd_ready <= 1'b1;
                            end
                        end else begin
                            col_cnt <= col_cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b0;
                    if (op == CMD_CLEAR) begin
                        top_row <= '0;
                    end else begin
                        top_row <= top_row + 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/vram_scroll_controller.md
# vram_scroll_controller

Sits between `character_writer` and the VRAM write port and owns the display's `top_row`. It passes character writes through, translating the logical screen row to a physical VRAM row. It also executes two commands that take over the write port: scroll one line (blank the new bottom line, then advance `top_row`) and clear screen (blank all VRAM, then zero `top_row`). Its `top_row` output drives the `hdmi` block.

## Interface
- `VISIBLE_ROWS`, default 24: rows shown on screen, 1..32.
- `COLS`, default 80: columns per row, 1..128.
- `BLANK_BYTE`, default 8'h20: byte written by clear operations.
- `clk` in 1: system (pixel) clock. One clock domain; everything is synchronous to `clk`.
- `reset` in 1: synchronous, active-high reset.
- `char_valid` in 1, `char_ready` out 1: character write handshake.
- `char_row` in 5, `char_col` in 7, `char_byte` in 8: logical row (0 = top visible line), column, byte.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake.
- `cmd_op` in 1: 0 = SCROLL, 1 = CLEAR.
- `write_valid` out 1, `write_ready` in 1: VRAM write port handshake.
- `write_row` out 5, `write_col` out 7, `write_byte` out 8: VRAM write address and data.
- `top_row` out 5: physical row shown at the top of the screen.
- `busy` out 1: high in any state other than IDLE.

## Operation
- A transfer happens on any cycle where valid and ready are both high.
- A source holds valid and its payload stable until the transfer.
- States: IDLE, SCROLL, CLEAR, DONE.
- IDLE:
  - Pass-through: `write_valid = char_valid`.
  - `char_ready = write_ready`, but only when `cmd_valid` is low.
  - `write_row = (char_row + top_row) mod 32` (5-bit wrap); `write_col = char_col`; `write_byte = char_byte`.
- Command arrival in IDLE:
  - `cmd_valid` high forces `char_ready = 0` and `write_valid = 0` that cycle. Commands win over a simultaneous character write.
  - Next state is SCROLL or CLEAR according to `cmd_op`. `cmd_op` is sampled on the transition.
  - `col_cnt` is loaded with 0.
  - SCROLL: `row_cnt` is loaded with `(top_row + VISIBLE_ROWS) mod 32`.
  - CLEAR: `row_cnt` is loaded with 0.
- SCROLL:
  - Outputs `write_valid = 1`, `write_row = row_cnt`, `write_col = col_cnt`, `write_byte = BLANK_BYTE`. `char_ready = 0`.
  - Each transfer increments `col_cnt`.
  - On the transfer with `col_cnt == COLS-1`: go to DONE.
- CLEAR:
  - Same outputs as SCROLL.
  - Each transfer with `col_cnt == COLS-1` sets `col_cnt` to 0 and increments `row_cnt`.
  - On the transfer with `row_cnt == 31` and `col_cnt == COLS-1`: go to DONE.
  - All 32 physical rows are cleared, not only the visible ones.
- DONE:
  - `cmd_ready = 1` for exactly this one cycle. `cmd_valid` is still high, so the command transfers here.
  - `top_row` becomes `top_row + 1` (mod 32) after SCROLL, or 0 after CLEAR. The new value is visible on the next cycle.
  - Next state is IDLE.
- `cmd_ready` is low in every state except DONE.
- Character writes issued during a command stall and complete afterwards, using the new `top_row`.
- `cmd_op` changes while not in IDLE are ignored.

## Timing
- Reset values: state IDLE, `top_row` 0, `row_cnt` 0, `col_cnt` 0, `busy` 0, `cmd_ready` 0.
- While reset is high, `write_valid` and `char_ready` follow the IDLE pass-through rules.
- Reset in the middle of a command aborts it: the clear is left partial, `top_row` returns to 0, and no `cmd_ready` pulse is issued.
- Pass-through latency is 0 cycles (combinational).
- SCROLL with `write_ready` held high: `cmd_ready` rises exactly `COLS + 1` cycles after the IDLE cycle that saw `cmd_valid`.
- CLEAR with `write_ready` held high: the same delay is `32*COLS + 1` cycles.
- Each low cycle of `write_ready` adds one cycle; the counters hold.
- `row_cnt` and `top_row` wrap modulo 32. `VISIBLE_ROWS = 32` is legal: SCROLL then clears the current `top_row` line.
- Back-to-back commands: at least one IDLE cycle separates them (DONE→IDLE). A command waiting in that IDLE cycle again blocks character writes.

## Structure
- Shared package `vram_pkg` holds:
  - `VRAM_ROW_W = 5`, `VRAM_COL_W = 7`, `VRAM_ROWS = 32`.
  - `typedef enum logic {CMD_SCROLL, CMD_CLEAR} vram_cmd_t`.
  - The state enum `scroll_state_t`.
- The `vram` and `hdmi` blocks import the same width constants.
- A single module with no sub-modules. The blanking counters and the pass-through mux are small enough to inline.

## Test plan
- Reset, then char write row 3, col 10, byte 0x41 with `top_row` 0 → VRAM write (3, 10, 0x41) in the same cycle. `top_row` = 0, `busy` = 0.
- SCROLL with `top_row` 0, defaults, `write_ready` = 1 → 80 writes of 0x20 to row 24, cols 0..79 in order. `cmd_ready` pulses on cycle 81. `top_row` = 1 afterwards.
- Wrap: preload `top_row` = 31 via 31 SCROLLs, issue a SCROLL → blanks row (31+24) mod 32 = 23 and `top_row` = 0. A char write to row 2 then lands on physical row 2.
- SCROLL with `write_ready` toggling 1/0 every cycle → still exactly 80 unique writes. `cmd_ready` pulses once, on cycle 161.
- `cmd_valid` (CLEAR) and `char_valid` raised in the same cycle → `char_ready` = 0 until after DONE. 2560 blank writes (rows 0..31). The char write completes with `top_row` = 0.
- Assert `reset` midway through a CLEAR (after 1000 writes) → next cycle IDLE, `top_row` = 0, no `cmd_ready` pulse. A new CLEAR then restarts at row 0, col 0.
